// File: rtl/tinyqv_seq_pkg.sv
// rtl/tinyqv_seq_pkg.sv - shared state encoding and widths for the tinyQV nibble sequencer
package tinyqv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_LOAD_WB  = 2'd3
    } seq_state_e;

    localparam int NIBBLE_BITS = 3;
    localparam int PC_STEP_W   = 3;

    // Halfword length to byte step.
    function automatic logic [PC_STEP_W-1:0] pc_step(input logic [1:0] len);
        return {len, 1'b0};
    endfunction

endpackage

// File: rtl/tinyqv_seq_perf.sv
// rtl/tinyqv_seq_perf.sv - cycle/instret counters, compiled only with TINYQV_SEQ_PERF_EN
`ifdef TINYQV_SEQ_PERF_EN
module tinyqv_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_i,
    output logic [31:0] cycle_count_o,
    output logic [31:0] instret_count_o
);

    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire_i) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_count_o   = cycle_q;
    assign instret_count_o = instret_q;

endmodule
`endif

// File: rtl/tinyqv_nibble_sequencer.sv
// rtl/tinyqv_nibble_sequencer.sv - nibble sequencer for tinyQV; perf counters under TINYQV_SEQ_PERF_EN
module tinyqv_nibble_sequencer
    import tinyqv_seq_pkg::*;
#(
    parameter int NIBBLES       = 8,
    parameter int MAX_EXTRA_OPS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic [2:0]             additional_mem_ops,
    input  logic [1:0]             instr_len,
    input  logic                   load_data_ready,
    input  logic                   store_ack,
    output logic [NIBBLE_BITS-1:0] counter,
    output logic                   exec_active,
    output logic                   wb_active,
    output logic                   instr_accept,
    output logic                   mem_req,
    output logic                   mem_is_store,
    output logic                   mem_op_increment,
    output logic                   instr_complete,
    output logic [PC_STEP_W-1:0]   pc_advance,
    output logic [31:0]            cycle_count,
    output logic [31:0]            instret_count
);

    localparam logic [NIBBLE_BITS-1:0] LAST_NIBBLE = NIBBLE_BITS'(NIBBLES - 1);
    localparam logic [2:0]             MAX_OPS     = 3'(MAX_EXTRA_OPS);

    seq_state_e             state_q, state_d;
    logic [NIBBLE_BITS-1:0] counter_q, counter_d;
    logic                   is_load_q, is_load_d;
    logic                   is_store_q, is_store_d;
    logic [2:0]             ops_left_q, ops_left_d;
    logic [1:0]             instr_len_q, instr_len_d;

    logic accept_c, complete_c, increment_c, op_done_c, finish_c, last_nibble;

    assign last_nibble = (counter_q == LAST_NIBBLE);

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        ops_left_d  = ops_left_q;
        instr_len_d = instr_len_q;
        accept_c    = 1'b0;
        complete_c  = 1'b0;
        increment_c = 1'b0;
        op_done_c   = 1'b0;
        finish_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (instr_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                counter_d = counter_q + 1'b1;
                if (last_nibble) begin
                    if (is_load_q || is_store_q) begin
                        state_d   = ST_MEM_WAIT;
                        counter_d = '0;
                    end else begin
                        finish_c = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                counter_d = '0;
                if (is_store_q) begin
                    op_done_c = store_ack;
                end else if (load_data_ready) begin
                    state_d = ST_LOAD_WB;
                end
            end
            default: begin
                counter_d = counter_q + 1'b1;
                op_done_c = last_nibble;
            end
        endcase

        // Repeated memory ops re-run EXEC so the core can step the base register.
        if (op_done_c) begin
            if (ops_left_q != 3'd0) begin
                ops_left_d  = ops_left_q - 3'd1;
                increment_c = 1'b1;
                state_d     = ST_EXEC;
                counter_d   = '0;
            end else begin
                finish_c = 1'b1;
            end
        end

        if (finish_c) begin
            complete_c = 1'b1;
            counter_d  = '0;
            if (instr_valid) begin
                accept_c = 1'b1;
                state_d  = ST_EXEC;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (accept_c) begin
            is_load_d   = is_load;
            is_store_d  = is_store;
            instr_len_d = instr_len;
            ops_left_d  = (additional_mem_ops > MAX_OPS) ? MAX_OPS : additional_mem_ops;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            ops_left_q  <= '0;
            instr_len_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            ops_left_q  <= ops_left_d;
            instr_len_q <= instr_len_d;
        end
    end

    // Pulses are masked during reset so an interrupted instruction never retires.
    assign instr_accept     = accept_c & ~rst;
    assign instr_complete   = complete_c & ~rst;
    assign mem_op_increment = increment_c & ~rst;
    assign pc_advance       = instr_complete ? pc_step(instr_len_q) : '0;
    assign counter          = counter_q;
    assign exec_active      = (state_q == ST_EXEC);
    assign wb_active        = (state_q == ST_LOAD_WB);
    assign mem_req          = (state_q == ST_MEM_WAIT);
    assign mem_is_store     = (state_q == ST_MEM_WAIT) && is_store_q;

`ifdef TINYQV_SEQ_PERF_EN
    tinyqv_seq_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .retire_i       (instr_complete),
        .cycle_count_o  (cycle_count),
        .instret_count_o(instret_count)
    );
`else
    assign cycle_count   = 32'd0;
    assign instret_count = 32'd0;
`endif

endmodule

// File: tb/tb_tinyqv_nibble_sequencer.sv
// tb/tb_tinyqv_nibble_sequencer.sv - directed self-checking bench for tinyqv_nibble_sequencer
module tb_tinyqv_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  additional_mem_ops;
    logic [1:0]  instr_len;
    logic        load_data_ready;
    logic        store_ack;
    logic [2:0]  counter;
    logic        exec_active;
    logic        wb_active;
    logic        instr_accept;
    logic        mem_req;
    logic        mem_is_store;
    logic        mem_op_increment;
    logic        instr_complete;
    logic [2:0]  pc_advance;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tinyqv_nibble_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .is_load           (is_load),
        .is_store          (is_store),
        .additional_mem_ops(additional_mem_ops),
        .instr_len         (instr_len),
        .load_data_ready   (load_data_ready),
        .store_ack         (store_ack),
        .counter           (counter),
        .exec_active       (exec_active),
        .wb_active         (wb_active),
        .instr_accept      (instr_accept),
        .mem_req           (mem_req),
        .mem_is_store      (mem_is_store),
        .mem_op_increment  (mem_op_increment),
        .instr_complete    (instr_complete),
        .pc_advance        (pc_advance),
        .cycle_count       (cycle_count),
        .instret_count     (instret_count)
    );

    // {counter, exec, wb, accept, mem_req, mem_is_store, inc, complete, pc_advance}
    function automatic logic [13:0] outs();
        return {counter, exec_active, wb_active, instr_accept, mem_req, mem_is_store,
                mem_op_increment, instr_complete, pc_advance};
    endfunction

    function automatic logic [13:0] mk(input logic [2:0] cnt, input logic ex, input logic wb,
                                       input logic acc, input logic mr, input logic ms,
                                       input logic inc, input logic cmp, input logic [2:0] pc);
        return {cnt, ex, wb, acc, mr, ms, inc, cmp, pc};
    endfunction

    task automatic clear_inputs();
        instr_valid        = 1'b0;
        is_load            = 1'b0;
        is_store           = 1'b0;
        additional_mem_ops = 3'd0;
        instr_len          = 2'd0;
        load_data_ready    = 1'b0;
        store_ack          = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        exp = '0;
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), exp);
        end
        checks++;
        if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %h/%h expected 0/0", cycle_count, instret_count);
        end
    endtask

    task automatic test_alu();
        logic [13:0] exp;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_len   = 2'd2;
        #1;
        exp = mk(3'd0, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL alu_accept: got %h expected %h", outs(), exp);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            #1;
            exp = mk(3'(i), 1, 0, 0, 0, 0, 0, i == 7, (i == 7) ? 3'd4 : 3'd0);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL alu_cycle%0d: got %h expected %h", i, outs(), exp);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL alu_idle: got %h expected %h", outs(), 14'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        int completes = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_len   = 2'd1;
        #1;
        checks++;
        if (instr_accept !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_accept: got %b expected 1", instr_accept);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            instr_valid = (i < 31);
            #1;
            exp = mk(3'(i % 8), 1, 0, (i % 8 == 7) && (i < 31), 0, 0, 0, i % 8 == 7,
                     (i % 8 == 7) ? 3'd2 : 3'd0);
            if (instr_complete === 1'b1) completes++;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", i, outs(), exp);
            end
        end
        checks++;
        if (completes !== 4) begin
            errors++;
            $display("FAIL b2b_completes: got %0d expected 4", completes);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL b2b_idle: got %h expected %h", outs(), 14'd0);
        end
    endtask

    // Accept at t0, EXEC t1..t8, MEM_WAIT t9..t13 (ready at t13), LOAD_WB t14..t21.
    task automatic test_load();
        logic [13:0] exp;
        logic [2:0]  cnt;
        @(negedge clk);
        instr_valid = 1'b1;
        is_load     = 1'b1;
        instr_len   = 2'd2;
        #1;
        checks++;
        if (instr_accept !== 1'b1) begin
            errors++;
            $display("FAIL load_accept: got %b expected 1", instr_accept);
        end
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk);
            instr_valid     = (t == 5);
            is_load         = 1'b0;
            store_ack       = (t == 3) || (t == 10);
            load_data_ready = (t == 13);
            #1;
            cnt = (t <= 8) ? 3'(t - 1) : (t >= 14 && t <= 21) ? 3'(t - 14) : 3'd0;
            exp = mk(cnt, t <= 8, t >= 14 && t <= 21, 0, t >= 9 && t <= 13, 0, 0, t == 21,
                     (t == 21) ? 3'd4 : 3'd0);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL load_t%0d: got %h expected %h", t, outs(), exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_store_multi();
        logic [13:0] exp;
        int accepts = 0;
        int r;
        int p;
        @(negedge clk);
        instr_valid        = 1'b1;
        is_store           = 1'b1;
        additional_mem_ops = 3'd2;
        instr_len          = 2'd2;
        store_ack          = 1'b1;
        #1;
        checks++;
        if (instr_accept !== 1'b1) begin
            errors++;
            $display("FAIL store_accept: got %b expected 1", instr_accept);
        end
        for (int t = 1; t <= 28; t++) begin
            @(negedge clk);
            instr_valid        = 1'b0;
            is_store           = 1'b0;
            additional_mem_ops = 3'd0;
            #1;
            r = (t - 1) / 9;
            p = (t - 1) % 9;
            if (t == 28) exp = 14'd0;
            else exp = mk((p < 8) ? 3'(p) : 3'd0, p < 8, 0, 0, p == 8, p == 8,
                          (p == 8) && (r < 2), (p == 8) && (r == 2),
                          ((p == 8) && (r == 2)) ? 3'd4 : 3'd0);
            if (instr_accept === 1'b1) accepts++;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL store_t%0d: got %h expected %h", t, outs(), exp);
            end
        end
        checks++;
        if (accepts !== 0) begin
            errors++;
            $display("FAIL store_extra_accepts: got %0d expected 0", accepts);
        end
        clear_inputs();
    endtask

    // Load with ready in the first MEM_WAIT cycle (t9), reset at LOAD_WB counter 3 (t13).
    task automatic test_reset_mid();
        logic [13:0] exp;
        @(negedge clk);
        instr_valid = 1'b1;
        is_load     = 1'b1;
        instr_len   = 2'd1;
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            instr_valid     = 1'b0;
            is_load         = 1'b0;
            load_data_ready = (t == 9);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (counter !== 3'd3 || wb_active !== 1'b1 || instr_complete !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: got cnt=%0d wb=%b cmp=%b expected cnt=3 wb=1 cmp=0",
                     counter, wb_active, instr_complete);
        end
        @(negedge clk);
        rst             = 1'b0;
        load_data_ready = 1'b0;
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL midreset_post: got %h expected %h", outs(), 14'd0);
        end
        @(negedge clk);
        instr_valid = 1'b1;
        instr_len   = 2'd2;
        #1;
        exp = mk(3'd0, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL midreset_reaccept: got %h expected %h", outs(), exp);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        exp = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL midreset_exec: got %h expected %h", outs(), exp);
        end
        repeat (8) @(negedge clk);
        clear_inputs();
    endtask

    // Accepts at cycles 0,9,..,81 after reset release; sample after 100 edges.
    task automatic test_perf();
        logic [31:0] exp_cyc;
        logic [31:0] exp_ret;
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            instr_valid = (j % 9 == 0) && (j < 90);
        end
        #1;
`ifdef TINYQV_SEQ_PERF_EN
        exp_cyc = 32'd100;
        exp_ret = 32'd10;
`else
        exp_cyc = 32'd0;
        exp_ret = 32'd0;
`endif
        checks++;
        if (cycle_count !== exp_cyc) begin
            errors++;
            $display("FAIL perf_cycles: got %0d expected %0d", cycle_count, exp_cyc);
        end
        checks++;
        if (instret_count !== exp_ret) begin
            errors++;
            $display("FAIL perf_instret: got %0d expected %0d", instret_count, exp_ret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store_multi();
        test_reset_mid();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
